// File: rtl/tb_status_periph_if.sv
// Core data-port bus between a load/store master and the status peripheral.
// One request per cycle; the grant is combinational and the response arrives one cycle later.
interface tb_status_periph_if;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );
  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/tb_status_periph.sv
// Simulation status peripheral: stdout FIFO, test pass/fail pulses, exit code and STATUS register.
// Optional free-running CYCLES counter enabled by defining TB_STATUS_CYCLE_COUNTER_EN.
module tb_status_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  tb_status_periph_if.slave   bus,
  output logic                char_valid_o,
  output logic [7:0]          char_o,
  input  logic                char_ready_i,
  output logic                tests_passed_o,
  output logic                tests_failed_o,
  output logic                exit_valid_o,
  output logic [31:0]         exit_value_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [2:0] W_PRINT = 3'd0, W_TEST = 3'd1, W_EXIT = 3'd2,
                         W_CYCLES = 3'd3, W_STATUS = 3'd4;
  localparam logic [31:0] PASS_CODE = 32'd123456789;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          passed_q, passed_d, failed_q, failed_d;
  logic          exit_valid_q, exit_valid_d;
  logic [31:0]   exit_value_q, exit_value_d;
  logic [31:0]   cyc_val;

  logic       in_win, full, empty, gnt, wr_hit, push, pop;
  logic [2:0] word;
  logic       unused_bits;

  assign unused_bits = ^{bus.data_be[3:1], bus.data_addr[1:0]};

`ifdef TB_STATUS_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;
  assign cyc_d   = (wr_hit && word == W_CYCLES) ? 32'h0 : cyc_q + 32'd1;
  assign cyc_val = cyc_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end
`else
  assign cyc_val = 32'h0;
`endif

  always_comb begin
    in_win = bus.data_addr[31:5] == BASE_ADDR[31:5];
    word   = bus.data_addr[4:2];
    full   = level_q == LW'(FIFO_DEPTH);
    empty  = level_q == '0;
    // A full FIFO stalls PRINT writes; pushing while popping a full FIFO is never allowed.
    gnt    = !rst_i && bus.data_req && in_win && !(bus.data_we && word == W_PRINT && full);
    wr_hit = gnt && bus.data_we;
    push   = wr_hit && word == W_PRINT && bus.data_be[0];
    pop    = !empty && char_ready_i;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);

    rvalid_d = gnt;
    rdata_d  = 32'h0;
    if (gnt && !bus.data_we) begin
      case (word)
        W_CYCLES: rdata_d = cyc_val;
        W_STATUS: rdata_d = {23'h0, full, 3'h0, 5'(level_q)};
        default:  rdata_d = 32'h0;
      endcase
    end

    passed_d     = wr_hit && word == W_TEST && bus.data_wdata == PASS_CODE;
    failed_d     = wr_hit && word == W_TEST && bus.data_wdata != PASS_CODE;
    exit_valid_d = wr_hit && word == W_EXIT;
    exit_value_d = exit_valid_d ? bus.data_wdata : exit_value_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
    end
  end

  // Storage needs no reset: the head is only exposed while the level is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_wdata[7:0];
  end

  assign bus.data_gnt    = gnt;
  assign bus.data_rvalid = rvalid_q;
  assign bus.data_rdata  = rdata_q;
  assign char_valid_o    = !empty;
  assign char_o          = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign tests_passed_o  = passed_q;
  assign tests_failed_o  = failed_q;
  assign exit_valid_o    = exit_valid_q;
  assign exit_value_o    = exit_value_q;
endmodule

// File: tb/tb_tb_status_periph.sv
// Bench for tb_status_periph: directed steps plus a random phase, checked cycle by cycle
// against a queue-based behavioural model of the register map.
module tb_tb_status_periph;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 4;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic        clk = 1'b0;
  logic        rst;
  logic        char_valid, char_ready, passed, failed, exitv;
  logic [7:0]  char_o;
  logic [31:0] exitval;
  int          total = 0, bad = 0;
  bit          mon_en = 1'b0;

  tb_status_periph_if bus();

  tb_status_periph #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .char_valid_o(char_valid), .char_o(char_o), .char_ready_i(char_ready),
    .tests_passed_o(passed), .tests_failed_o(failed),
    .exit_valid_o(exitv), .exit_value_o(exitval)
  );

  always #5 clk = ~clk;

  // Behavioural model state: stdout characters as a queue, response and pulses as plain values.
  logic [7:0]  q[$];
  bit          m_rv, m_rd, m_pass, m_fail, m_exv;
  logic [31:0] m_rdata, m_exval, m_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit exp_gnt();
    return !rst && bus.data_req === 1'b1 && (bus.data_addr & 32'hFFFF_FFE0) == BASE &&
           !(bus.data_we && bus.data_addr[4:0] == 5'h00 && q.size() == DEPTH);
  endfunction

  task automatic model_step();
    bit g;
    logic [4:0] off;
    off = bus.data_addr[4:0];
    if (rst) begin
      q.delete();
      {m_rv, m_rd, m_pass, m_fail, m_exv} = '0;
      m_rdata = '0; m_exval = '0; m_cyc = '0;
    end else begin
      g = exp_gnt();
      m_rv = g;
      m_rd = g && !bus.data_we;
      m_rdata = 32'h0;
      if (m_rd && off == 5'h0C) begin
`ifdef TB_STATUS_CYCLE_COUNTER_EN
        m_rdata = m_cyc;
`endif
      end
      if (m_rd && off == 5'h10) m_rdata = {23'h0, q.size() == DEPTH, 3'h0, 5'(q.size())};
      m_pass = g && bus.data_we && off == 5'h04 && bus.data_wdata == MAGIC;
      m_fail = g && bus.data_we && off == 5'h04 && bus.data_wdata != MAGIC;
      m_exv  = g && bus.data_we && off == 5'h08;
      if (m_exv) m_exval = bus.data_wdata;
      m_cyc = (g && bus.data_we && off == 5'h0C) ? 32'h0 : m_cyc + 32'd1;
      if (q.size() > 0 && char_ready) void'(q.pop_front());
      if (g && bus.data_we && off == 5'h00 && bus.data_be[0]) q.push_back(bus.data_wdata[7:0]);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk); #2;
    if (mon_en) begin
      chk("gnt", 32'(bus.data_gnt), 32'(exp_gnt()));
      chk("rvalid", 32'(bus.data_rvalid), 32'(m_rv));
      if (m_rv && m_rd) chk("rdata", bus.data_rdata, m_rdata);
      chk("char_valid", 32'(char_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("char_o", 32'(char_o), 32'(q[0]));
      chk("passed", 32'(passed), 32'(m_pass));
      chk("failed", 32'(failed), 32'(m_fail));
      chk("exit_valid", 32'(exitv), 32'(m_exv));
      chk("exit_value", exitval, m_exval);
    end
  end

  task automatic acc(input bit we, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input bit rnd_rdy);
    int n;
    @(negedge clk);
    bus.data_req = 1'b1; bus.data_we = we; bus.data_addr = a;
    bus.data_be = be; bus.data_wdata = wd;
    if (rnd_rdy) char_ready = 1'($urandom_range(0, 1));
    n = 0;
    #1;
    while (bus.data_gnt !== 1'b1 && n < 50) begin
      @(negedge clk);
      if (rnd_rdy) char_ready = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    chk("grant_wait", 32'(bus.data_gnt), 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.data_req = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    acc(1'b0, a, 4'hF, 32'h0, 1'b0);
    idle();
    #2 d = bus.data_rdata;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  drain [4];
    logic [31:0] a, wd;
    drain[0] = 8'h63; drain[1] = 8'h64; drain[2] = 8'h65; drain[3] = 8'h00;

    rst = 1'b1; char_ready = 1'b0;
    bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0;
    bus.data_be = '0; bus.data_wdata = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_gnt", 32'(bus.data_gnt), 0);
    chk("rst_rvalid", 32'(bus.data_rvalid), 0);
    chk("rst_rdata", bus.data_rdata, 0);
    chk("rst_char_valid", 32'(char_valid), 0);
    chk("rst_char_o", 32'(char_o), 0);
    chk("rst_pulses", 32'({passed, failed, exitv}), 0);
    chk("rst_exit_value", exitval, 0);
    mon_en = 1'b1;
    @(negedge clk) rst = 1'b0;

    // Cycle counter after reset release, then cleared by a write.
    repeat (10) @(negedge clk);
    rd(BASE + 32'h0C, d);
`ifdef TB_STATUS_CYCLE_COUNTER_EN
    total++;
    assert (d >= 32'd9 && d <= 32'd13) else begin
      bad++; $error("FAIL cycles_after_reset got=%0d exp=about 10", d);
    end
`else
    chk("cycles_absent", d, 32'h0);
`endif
    acc(1'b1, BASE + 32'h0C, 4'hF, 32'h1234, 1'b0);
    rd(BASE + 32'h0C, d);
`ifdef TB_STATUS_CYCLE_COUNTER_EN
    total++;
    assert (d <= 32'd3) else begin
      bad++; $error("FAIL cycles_cleared got=%0d exp=<=3", d);
    end
`else
    chk("cycles_write_ignored", d, 32'h0);
`endif

    // Two characters out, one per cycle, back-to-back writes.
    char_ready = 1'b1;
    acc(1'b1, BASE, 4'h1, 32'h41, 1'b0);
    acc(1'b1, BASE, 4'h1, 32'h42, 1'b0);
    #1 chk("print_first", 32'(char_o), 32'h41);
    idle();
    #2 chk("print_second", 32'(char_o), 32'h42);
    @(negedge clk); #2 chk("print_drained", 32'(char_valid), 0);
    rd(BASE + 32'h10, d);
    chk("status_empty", d, 32'h0);

    // Fill to depth, stall the fifth write, then release.
    char_ready = 1'b0;
    for (int i = 0; i < 4; i++) acc(1'b1, BASE, 4'h1, 32'h61 + 32'(i), 1'b0);
    rd(BASE + 32'h10, d);
    chk("status_full", d, 32'h104);
    @(negedge clk);
    bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = BASE;
    bus.data_be = 4'h1; bus.data_wdata = 32'h65;
    #1 chk("stall_gnt0", 32'(bus.data_gnt), 0);
    @(negedge clk); #1 chk("stall_gnt1", 32'(bus.data_gnt), 0);
    @(negedge clk) char_ready = 1'b1;
    #1 chk("stall_gnt2", 32'(bus.data_gnt), 0);
    @(negedge clk); #1 chk("stall_release", 32'(bus.data_gnt), 1);
    for (int i = 0; i < 4; i++) begin
      idle();
      #2 chk("drain_order", 32'(char_o), 32'(drain[i]));
    end

    // Test pass/fail pulses.
    acc(1'b1, BASE + 32'h04, 4'hF, MAGIC, 1'b0);
    idle();
    #2 chk("passed_pulse", 32'({passed, failed}), 32'b10);
    @(negedge clk); #2 chk("passed_clear", 32'(passed), 0);
    acc(1'b1, BASE + 32'h04, 4'hF, 32'd7, 1'b0);
    idle();
    #2 chk("failed_pulse", 32'({passed, failed}), 32'b01);

    // Exit code latch.
    acc(1'b1, BASE + 32'h08, 4'hF, 32'h3, 1'b0);
    idle();
    #2 chk("exit_pulse", 32'(exitv), 1);
    chk("exit_value", exitval, 32'h3);
    @(negedge clk); #2 chk("exit_pulse_end", 32'(exitv), 0);
    chk("exit_held", exitval, 32'h3);

    // PRINT without byte lane 0, unmapped and write-only reads, read-only write.
    acc(1'b1, BASE, 4'hE, 32'h55, 1'b0);
    idle();
    #2 chk("print_be0_off", 32'(char_valid), 0);
    rd(BASE + 32'h14, d); chk("unmapped_read", d, 0);
    rd(BASE + 32'h00, d); chk("wo_read", d, 0);
    acc(1'b1, BASE + 32'h10, 4'hF, 32'hFFFF_FFFF, 1'b0);
    rd(BASE + 32'h10, d); chk("ro_write_ignored", d, 0);

    // Just outside the window: never granted, never answered.
    @(negedge clk);
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = BASE + 32'h20;
    for (int k = 0; k < 3; k++) begin
      #1 chk("oow_gnt", 32'(bus.data_gnt), 0);
      #1 chk("oow_rvalid", 32'(bus.data_rvalid), 0);
      @(negedge clk);
    end
    bus.data_req = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 250; i++) begin
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) wd = MAGIC;
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        bus.data_req = 1'b1; bus.data_we = 1'($urandom_range(0, 1));
        bus.data_addr = ($urandom_range(0, 1) == 0) ? BASE + 32'h20 : BASE ^ 32'h8000_0000;
        char_ready = 1'($urandom_range(0, 1));
      end else begin
        a = BASE + 32'(4 * $urandom_range(0, 7));
        acc(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), wd, 1'b1);
      end
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();

    // Reset lands on a granted read: its response must never appear.
    char_ready = 1'b0;
    acc(1'b1, BASE, 4'h1, 32'h77, 1'b0);
    acc(1'b1, BASE + 32'h08, 4'hF, 32'hDEAD_BEEF, 1'b0);
    idle();
    @(negedge clk);
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = BASE + 32'h10;
    #1 chk("pre_rst_gnt", 32'(bus.data_gnt), 1);
    #2 rst = 1'b1;
    @(negedge clk);
    bus.data_req = 1'b0;
    #2;
    chk("rst_cancel_rvalid", 32'(bus.data_rvalid), 0);
    chk("rst_fifo_empty", 32'(char_valid), 0);
    chk("rst_char_zero", 32'(char_o), 0);
    chk("rst_exit_cleared", exitval, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tb_status_periph.md
TB_STATUS_PERIPH -- requirements
Module: tb_status_periph

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000: base of the 32-byte register window (addr_i[31:5] == BASE_ADDR[31:5]).
REQ-002 Parameter FIFO_DEPTH, default 4: stdout character buffer entries; power of two, 2..16.
REQ-003 clk_i  in  1  single clock, all logic rising-edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 data_req_i  in  1  bus request from core data port.
REQ-006 data_addr_i  in  32  byte address.
REQ-007 data_we_i  in  1  1 = write, 0 = read.
REQ-008 data_be_i  in  4  byte enables.
REQ-009 data_wdata_i  in  32  write data.
REQ-010 data_gnt_o  out  1  request accepted this cycle.
REQ-011 data_rvalid_o  out  1  response valid.
REQ-012 data_rdata_o  out  32  read data, valid with data_rvalid_o.
REQ-013 char_valid_o  out  1  stdout character available.
REQ-014 char_o  out  8  stdout character.
REQ-015 char_ready_i  in  1  consumer accepts char_o.
REQ-016 tests_passed_o / tests_failed_o  out  1 each  single-cycle status pulses.
REQ-017 exit_valid_o  out  1  single-cycle exit pulse; exit_value_o  out  32  latched exit code.

Function
REQ-018 Register map (offset from BASE_ADDR): 0x00 PRINT (W), 0x04 TEST (W), 0x08 EXIT (W), 0x0C CYCLES (R), 0x10 STATUS (R: [4:0] FIFO level, [8] FIFO full); other offsets unmapped.
REQ-019 data_gnt_o = data_req_i && address in window, except a PRINT write while FIFO full is not granted (stall) until a slot frees.
REQ-020 Every granted access produces data_rvalid_o exactly one cycle after grant; back-to-back grants give back-to-back rvalids.
REQ-021 Reads of write-only or unmapped offsets return 32'h0; writes to read-only or unmapped offsets have no effect; both still respond.
REQ-022 PRINT write with data_be_i[0]=1 pushes data_wdata_i[7:0] into FIFO; be[0]=0 pushes nothing.
REQ-023 FIFO: char_valid_o = not empty; char_o = head entry; pop on char_valid_o && char_ready_i; simultaneous push and pop when full is not possible (stall per REQ-019); simultaneous push and pop otherwise keeps level unchanged.
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; level counts 0..FIFO_DEPTH.
REQ-025 TEST write of 32'd123456789 asserts tests_passed_o for exactly the cycle after grant; any other value asserts tests_failed_o for that cycle.
REQ-026 EXIT write latches data_wdata_i into exit_value_o and asserts exit_valid_o for the cycle after grant; exit_value_o holds until next EXIT write or reset.
REQ-027 Status pulses never overlap: only one access granted per cycle.
REQ-028 Requests outside window are never granted and produce no response.

Reset
REQ-029 While rst_i high at a clock edge: FIFO emptied (char_valid_o=0, char_o=0), data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, tests_passed_o=0, tests_failed_o=0, exit_valid_o=0, exit_value_o=0, cycle counter=0.
REQ-030 Reset asserted with a response pending cancels that response; no rvalid after reset.

Configuration
REQ-031 Macro TB_STATUS_CYCLE_COUNTER_EN defined: 32-bit free-running counter, increments every non-reset cycle, wraps 32'hFFFF_FFFF -> 0, readable at CYCLES; write to CYCLES clears it to 0.
REQ-032 Macro undefined: no counter logic; CYCLES reads 32'h0, writes ignored.

Verification
REQ-033 Write PRINT 0x41,0x42 with char_ready_i=1 -> char_o 0x41 then 0x42, one per cycle, FIFO level returns to 0.
REQ-034 char_ready_i=0, five PRINT writes (depth 4) -> four granted, fifth stalls gnt=0; STATUS read not possible while stalled; raise ready -> fifth granted next cycle, order preserved.
REQ-035 TEST write 123456789 -> tests_passed_o pulses one cycle, tests_failed_o stays 0; TEST write 7 -> tests_failed_o pulses.
REQ-036 EXIT write 0x0000_0003 -> exit_valid_o one-cycle pulse, exit_value_o=3 held afterwards.
REQ-037 With macro: reset release, read CYCLES after 10 cycles -> value 10±1 per grant timing; write CYCLES then read -> small value; without macro -> 0.
REQ-038 Granted read outstanding, rst_i asserted next edge -> data_rvalid_o stays 0, all outputs at reset values.
